// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the data width, the number of restoring-division steps, the FSM
// state encoding and small sign helpers used by muldiv_hilo.
package muldiv_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  // Absolute value of a 32-bit operand when treated as signed; unsigned
  // operands pass through. 0x80000000 maps to itself, which is the correct
  // unsigned magnitude 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negation.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider.
// One quotient bit per 'step' cycle, STEPS cycles per division.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        abandon the current division and zero the step counter
//   load         capture dividend/divisor magnitudes, start at step 0
//   step         perform one restoring step
//   dividend     unsigned dividend (sampled with load)
//   divisor      unsigned divisor  (sampled with load, must be nonzero)
//   quotient     quotient after the step being performed this cycle
//   remainder    remainder after the step being performed this cycle
//   last         high during the final step; quotient/remainder are final
module div_core #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int STEPS = muldiv_pkg::DIV_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CNT_W = $clog2(STEPS);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The dividend is shifted out of quo's MSB into the partial remainder
  // while quotient bits fill quo from the LSB. rem < dsr always holds, so
  // the shifted remainder fits in WIDTH+1 bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dsr};
    fits     = (shifted >= {1'b0, dsr});
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

  assign quotient  = quo_next;
  assign remainder = rem_next;
  assign last      = step && (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit for the execute stage.
// Multiply completes in one MUL cycle, divide in 32 DIV cycles via div_core;
// the pipeline is held through stallE until the result lands in HI/LO.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   startE     mult/div instruction present in execute
//   is_divE    0 = multiply, 1 = divide
//   hassignE   1 = signed, 0 = unsigned
//   srcaE      operand A / dividend / mthi-mtlo data
//   srcbE      operand B / divisor
//   hilo_enE   bit1 writes HI, bit0 writes LO from srcaE (idle only)
//   flushE     cancel any in-flight operation
//   hi, lo     HI/LO registers
//   stallE     hold the F/D/E pipeline registers
//   busy       FSM not idle
module muldiv_hilo #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             is_divE,
  input  logic             hassignE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic [1:0]       hilo_enE,
  input  logic             flushE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stallE,
  output logic             busy
);

  import muldiv_pkg::*;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sign_reg;

  logic             start_ok;
  logic             div_load;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic             div_last;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign start_ok = (state == IDLE) && startE && !flushE;
  assign div_load = start_ok && is_divE;
  assign stallE   = start_ok || (state == MUL) || (state == DIV);
  assign busy     = (state != IDLE);

  assign a_mag = magnitude(srcaE, hassignE);
  assign b_mag = magnitude(srcbE, hassignE);

  // Extending each operand to 64 bits (sign or zero) makes the low 64 bits
  // of a plain unsigned product equal the signed or unsigned result.
  always_comb begin
    a_ext   = {{WIDTH{sign_reg & a_reg[WIDTH-1]}}, a_reg};
    b_ext   = {{WIDTH{sign_reg & b_reg[WIDTH-1]}}, b_reg};
    product = a_ext * b_ext;
  end

  // Quotient negative when signs differ; remainder follows the dividend.
  always_comb begin
    neg_q = sign_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
    neg_r = sign_reg & a_reg[WIDTH-1];
    q_fix = apply_sign(q_mag, neg_q);
    r_fix = apply_sign(r_mag, neg_r);
  end

  div_core #(
    .WIDTH (WIDTH),
    .STEPS (DIV_STEPS)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst),
    .clear     (flushE),
    .load      (div_load),
    .step      (state == DIV),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (q_mag),
    .remainder (r_mag),
    .last      (div_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      sign_reg <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (flushE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            a_reg    <= srcaE;
            b_reg    <= srcbE;
            sign_reg <= hassignE;
            if (!is_divE)
              state <= MUL;
            else if (srcbE == '0)
              state <= DONE;
            else
              state <= DIV;
          end else begin
            if (hilo_enE[1]) hi <= srcaE;
            if (hilo_enE[0]) lo <= srcaE;
          end
        end
        MUL: begin
          hi    <= product[2*WIDTH-1:WIDTH];
          lo    <= product[WIDTH-1:0];
          state <= DONE;
        end
        DIV: begin
          if (div_last) begin
            lo    <= q_fix;
            hi    <= r_fix;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; only 32 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low; rst=0 resets immediately.
REQ-004 Port: startE  input  1  execute-stage mult/div instruction present.
REQ-005 Port: is_divE  input  1  0=multiply, 1=divide; sampled only with startE.
REQ-006 Port: hassignE  input  1  1=signed (mult/div), 0=unsigned (multu/divu).
REQ-007 Port: srcaE  input  32  operand A / dividend / mthi-mtlo data.
REQ-008 Port: srcbE  input  32  operand B / divisor.
REQ-009 Port: hilo_enE  input  2  bit1=write HI, bit0=write LO from srcaE (mthi/mtlo).
REQ-010 Port: flushE  input  1  cancel any in-flight operation.
REQ-011 Port: hi  output  32  HI register.
REQ-012 Port: lo  output  32  LO register.
REQ-013 Port: stallE  output  1  hold the F/D/E pipeline registers; consumed by the hazard unit.
REQ-014 Port: busy  output  1  FSM not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-016 IDLE & startE & !flushE SHALL latch operands and sign mode; next state MUL (is_divE=0) or DIV (is_divE=1).
REQ-017 MUL SHALL last exactly 1 cycle, write the 64-bit product {HI,LO} at its end, then go to DONE.
REQ-018 Signed multiply SHALL give the 64-bit two's-complement product; unsigned SHALL give the zero-extended product.
REQ-019 DIV SHALL run a 5-bit counter 0..31 (one restoring-division step per cycle, on magnitudes), write LO=quotient and HI=remainder at the end of count 31, then go to DONE.
REQ-020 Signed divide: quotient negated when operand signs differ; remainder takes the dividend's sign; 0x80000000/-1 SHALL give LO=0x80000000, HI=0.
REQ-021 Divisor zero SHALL transition IDLE->DONE directly, HI/LO unchanged.
REQ-022 DONE SHALL ignore startE, drop stallE, and return to IDLE next cycle, so the retained instruction is not re-issued.
REQ-023 stallE SHALL equal (IDLE & startE & !flushE) | MUL | DIV (combinational); mult stalls 2 cycles, div 33, div-by-zero 1.
REQ-024 In IDLE with startE=0, hilo_enE bits SHALL write srcaE into HI/LO at the next edge, no stall.
REQ-025 startE and hilo_enE both high SHALL start the operation; hilo_enE is ignored.
REQ-026 hilo_enE outside IDLE SHALL be ignored.
REQ-027 flushE in any state SHALL force IDLE next edge, HI/LO unchanged, counter cleared; flushE and startE together in IDLE SHALL not start.
REQ-028 hi/lo SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, latched operands=0; hence stallE=0 and busy=0 while startE=0.
REQ-030 Reset mid-operation SHALL abandon the result; no partial HI/LO write.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the state enum, WIDTH=32 and DIV_STEPS=32.
REQ-032 One sub-module div_core SHALL hold the iterative unsigned restoring divider (remainder/quotient shift registers, step counter); sign fix-up and HI/LO write stay in muldiv_hilo.

Verification
REQ-033 multu 0xFFFFFFFF*0x00000002 -> stallE high 2 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 mult -3*5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-035 div -7/2 -> stallE high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
REQ-036 divu 5/0 with HI=0xAAAA, LO=0x5555 -> stallE high 1 cycle, HI/LO unchanged.
REQ-037 flushE asserted in DIV cycle 10 -> IDLE next cycle, stallE=0, HI/LO unchanged; then hilo_enE=2'b10, srcaE=0x1234 -> HI=0x1234 next edge, LO unchanged.
REQ-038 rst=0 at DIV cycle 20 -> immediately IDLE, hi=lo=0, stallE=0; a div issued after release completes normally in 33 cycles.
